// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction fetch front end.
package cpu_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // nothing outstanding
    WAIT = 2'd1,  // one request outstanding, response will be kept
    DROP = 2'd2   // one request outstanding, response will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; low bits from EX are ignored.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle around the fetch unit: instruction memory request/response,
// EX redirect, and the IF/ID output handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  // Fetch unit side.
  modport master (
    output imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    input  imem_req_ready, imem_resp_valid, imem_resp_data,
    input  redirect, redirect_pc, out_ready
  );

  // Environment side (memory, EX stage, decode).
  modport slave (
    input  imem_req_valid, imem_req_addr, out_valid, out_pc, out_instr,
    output imem_req_ready, imem_resp_valid, imem_resp_data,
    output redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
// Flush wins over push and pop; head is read straight from storage.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_en, pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push & ~flush & ~full;
  assign pop_en  = pop & ~flush & ~empty;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_en) - CW'(pop_en);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, keeps at most one request
// in flight to instruction memory and buffers returned words for decode.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master fe
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_pc_q, req_pc_d;

  fetch_entry_t  push_entry, head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          fifo_push, fifo_pop;
  logic [CW:0]   used;
  logic          credit;
  logic          accept;

  // A slot is reserved for the outstanding request so a push never hits a full FIFO.
  assign used   = {1'b0, count} + (CW+1)'(state_q == WAIT);
  assign credit = (used < (CW+1)'(DEPTH));

  // Issue when idle, or back-to-back as the current response lands.
  assign fe.imem_req_valid = ~rst & ~fe.redirect & credit &
                             ((state_q == IDLE) | ((state_q == WAIT) & fe.imem_resp_valid));
  assign fe.imem_req_addr  = fetch_pc_q;
  assign accept            = fe.imem_req_valid & fe.imem_req_ready;

  assign push_entry = '{pc: req_pc_q, instr: fe.imem_resp_data};
  assign fifo_push  = (state_q == WAIT) & fe.imem_resp_valid & ~fe.redirect & ~full;
  assign fifo_pop   = fe.out_valid & fe.out_ready & ~fe.redirect;

  assign fe.out_valid = ~empty;
  assign fe.out_pc    = head.pc;
  assign fe.out_instr = head.instr;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .flush     (fe.redirect),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  // FSM next state plus fetch/request PC updates; redirect overrides everything.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    case (state_q)
      IDLE: if (accept) state_d = WAIT;
      WAIT: begin
        if (fe.redirect)            state_d = fe.imem_resp_valid ? IDLE : DROP;
        else if (fe.imem_resp_valid) state_d = accept ? WAIT : IDLE;
      end
      DROP: if (fe.imem_resp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);
      req_pc_d   = fetch_pc_q;
    end
    if (fe.redirect) fetch_pc_d = align_pc(fe.redirect_pc);
  end

  // FSM state and PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a behavioural variable-latency memory.
module tb_fetch_unit;

  logic clk;
  logic rst;
  fetch_unit_if bus();

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .fe  (bus)
  );

  int checks   = 0;
  int failures = 0;
  int acc_count = 0;
  int mem_lat   = 1;
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: a fixed, easily recognisable word per address.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accepts(input string name, input int target);
    int n;
    n = 0;
    while (acc_count < target && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (acc_count < target) check(name, 32'(acc_count), 32'(target));
  endtask

  task automatic drain_check(input string name);
    repeat (12) next_cycle();
    @(negedge clk);
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    bus.imem_req_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Memory model: one request at a time, response mem_lat cycles after accept.
  initial begin
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data  = 32'h0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
    mem_addr = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_busy = 1'b0;
      end else begin
        if (bus.imem_resp_valid) mem_busy = 1'b0;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
          check("single_outstanding", {31'b0, mem_busy}, 32'd0);
          mem_busy = 1'b1;
          mem_cnt  = mem_lat;
          mem_addr = bus.imem_req_addr;
          acc_count++;
          $display("accept addr=0x%08h", bus.imem_req_addr);
        end
      end
      @(posedge clk);
      #2;
      if (rst || !mem_busy) begin
        bus.imem_resp_valid = 1'b0;
      end else if (mem_cnt <= 1) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_resp_data  = instr_of(mem_addr);
      end else begin
        mem_cnt--;
        bus.imem_resp_valid = 1'b0;
      end
    end
  end

  // Monitor: every IF/ID transfer is matched against the expected queue.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (bus.out_valid && bus.out_ready && !bus.redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got pc 0x%08h, required no transfer", bus.out_pc);
        end else begin
          e = exp_q.pop_front();
          $display("xfer pc=0x%08h instr=0x%08h", bus.out_pc, bus.out_instr);
          check("out_pc", bus.out_pc, e);
          check("out_instr", bus.out_instr, instr_of(e));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    int base;
    rst = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.out_ready = 1'b0;
    bus.imem_req_ready = 1'b1;
    mem_lat = 1;

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming with a 1-cycle memory.
    base = acc_count;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) exp_q.push_back(32'(i * 4));
    @(negedge clk);
    check("c0_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("c0_req_addr", bus.imem_req_addr, 32'h0);
    check("c0_out_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("c1_req_addr", bus.imem_req_addr, 32'h4);
    check("c1_out_valid", {31'b0, bus.out_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("c2_req_addr", bus.imem_req_addr, 32'h8);
    check("c2_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("c2_out_pc", bus.out_pc, 32'h0);
    wait_accepts("stream_accepts", base + 8);
    next_cycle();
    bus.imem_req_ready = 1'b0;

    // Memory not ready: request held stable, PC does not advance.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
      check("stall_req_addr", bus.imem_req_addr, 32'h20);
      next_cycle();
    end
    bus.imem_req_ready = 1'b1;
    wait_accepts("stall_accept", base + 9);
    next_cycle();
    bus.imem_req_ready = 1'b0;
    drain_check("stream_drain");

    // Decode stall: exactly DEPTH accepts, then in-order drain.
    do_reset();
    base = acc_count;
    bus.imem_req_ready = 1'b1;
    for (int i = 0; i < 4; i++) exp_q.push_back(32'(i * 4));
    repeat (10) next_cycle();
    @(negedge clk);
    #1;
    check("full_accepts", 32'(acc_count - base), 32'd4);
    check("full_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    check("full_head_pc", bus.out_pc, 32'h0);
    next_cycle();
    bus.imem_req_ready = 1'b0;
    bus.out_ready = 1'b1;
    drain_check("full_drain");

    // Redirect while a response (PC 0x8) is in flight, 2-cycle memory.
    mem_lat = 2;
    do_reset();
    base = acc_count;
    bus.out_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    exp_q.push_back(32'h0);
    wait_accepts("redir_pre_accepts", base + 3);
    next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h0000_0103;
    @(negedge clk);
    check("redir_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("redir_next_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("drop_cycle_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    exp_q.push_back(32'h108);
    next_cycle();
    @(negedge clk);
    check("redir_first_addr", bus.imem_req_addr, 32'h100);
    wait_accepts("redir_post_accepts", base + 6);
    next_cycle();
    bus.imem_req_ready = 1'b0;
    drain_check("redir_drain");

    // Redirect coinciding with a response and a ready decode stage.
    mem_lat = 1;
    do_reset();
    base = acc_count;
    bus.out_ready = 1'b1;
    bus.imem_req_ready = 1'b1;
    next_cycle();
    next_cycle();
    bus.redirect = 1'b1;
    bus.redirect_pc = 32'h200;
    @(negedge clk);
    check("coinc_out_valid", {31'b0, bus.out_valid}, 32'd1);
    check("coinc_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    bus.redirect = 1'b0;
    @(negedge clk);
    check("coinc_next_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("coinc_next_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("coinc_next_addr", bus.imem_req_addr, 32'h200);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    wait_accepts("coinc_accepts", base + 4);
    next_cycle();
    bus.imem_req_ready = 1'b0;
    drain_check("coinc_drain");

    // Reset with two entries buffered and one request outstanding.
    do_reset();
    base = acc_count;
    bus.imem_req_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid_same", {31'b0, bus.out_valid}, 32'd1);
    check("midrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
    next_cycle();
    @(negedge clk);
    check("midrst_out_valid_next", {31'b0, bus.out_valid}, 32'd0);
    check("midrst_accepts", 32'(acc_count - base), 32'd3);
    next_cycle();
    rst = 1'b0;
    bus.imem_req_ready = 1'b0;
    @(negedge clk);
    check("postrst_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
    check("postrst_req_addr", bus.imem_req_addr, 32'h0);
    exp_q.push_back(32'h0);
    bus.out_ready = 1'b1;
    next_cycle();
    bus.imem_req_ready = 1'b1;
    wait_accepts("postrst_accept", base + 4);
    next_cycle();
    bus.imem_req_ready = 1'b0;
    drain_check("postrst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
